// File: rtl/sequenciador_de_programa_pkg.sv
// ---------------------------------------------------------------------------
// sequenciador_de_programa_pkg
// Shared definitions for the program sequencer: opcode constants, the FSM
// state encoding and the instruction field positions.
// Optional feature macro used by the slice: SEQ_BREAKPOINT_EN.
// ---------------------------------------------------------------------------
package sequenciador_de_programa_pkg;

    // Opcodes carried in instruction bits [8:6]; 3'b011 runs as a plain
    // 4-step instruction.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_HLT = 3'b110;
    localparam logic [2:0] OP_REP = 3'b111;

    // Instruction field positions.
    localparam int unsigned OPC_MSB = 8;
    localparam int unsigned OPC_LSB = 6;
    localparam int unsigned RX_MSB  = 5;
    localparam int unsigned RX_LSB  = 3;
    localparam int unsigned RY_MSB  = 2;
    localparam int unsigned RY_LSB  = 0;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_WAIT_IR   = 3'd2;
    localparam logic [2:0] ST_FETCH_IMM = 3'd3;
    localparam logic [2:0] ST_WAIT_IMM  = 3'd4;
    localparam logic [2:0] ST_EXEC      = 3'd5;
    localparam logic [2:0] ST_HALT      = 3'd6;

    typedef logic [8:0] instr_t;

    function automatic logic [2:0] opcode_of(input instr_t w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [2:0] rx_of(input instr_t w);
        return w[RX_MSB:RX_LSB];
    endfunction

    function automatic logic [2:0] ry_of(input instr_t w);
        return w[RY_MSB:RY_LSB];
    endfunction

endpackage

// File: rtl/sequenciador_de_programa_if.sv
// ---------------------------------------------------------------------------
// sequenciador_de_programa_if
// Bundles the sequencer's control and ROM signals.
//   master : sequencer side (drives mem_addr/mem_rd/iin/imm/counter/
//            exec_valid/done/busy/halted, receives run/stop/mem_data)
//   slave  : environment side (ROM + control logic), opposite directions
// With SEQ_BREAKPOINT_EN defined, bp_addr/bp_enable (in) and bp_hit (out)
// are added to the bundle.
// ---------------------------------------------------------------------------
interface sequenciador_de_programa_if #(
    parameter int unsigned PC_WIDTH = 5
);
    logic                run;
    logic                stop;
    logic [8:0]          mem_data;
    logic [PC_WIDTH-1:0] mem_addr;
    logic                mem_rd;
    logic [8:0]          iin;
    logic [8:0]          imm;
    logic [1:0]          counter;
    logic                exec_valid;
    logic                done;
    logic                busy;
    logic                halted;
`ifdef SEQ_BREAKPOINT_EN
    logic [PC_WIDTH-1:0] bp_addr;
    logic                bp_enable;
    logic                bp_hit;

    modport master (
        input  run, stop, mem_data, bp_addr, bp_enable,
        output mem_addr, mem_rd, iin, imm, counter, exec_valid, done, busy,
               halted, bp_hit
    );
    modport slave (
        output run, stop, mem_data, bp_addr, bp_enable,
        input  mem_addr, mem_rd, iin, imm, counter, exec_valid, done, busy,
               halted, bp_hit
    );
`else
    modport master (
        input  run, stop, mem_data,
        output mem_addr, mem_rd, iin, imm, counter, exec_valid, done, busy,
               halted
    );
    modport slave (
        output run, stop, mem_data,
        input  mem_addr, mem_rd, iin, imm, counter, exec_valid, done, busy,
               halted
    );
`endif
endinterface

// File: rtl/sequenciador_de_programa_contador_de_passos.sv
// ---------------------------------------------------------------------------
// contador_de_passos
// 2-bit execution step counter.
//   clock  : rising-edge clock
//   resetn : synchronous active-low reset (count -> 0)
//   clear  : synchronous clear, wins over enable
//   enable : advance count by one (wraps 3 -> 0)
//   count  : current step
// ---------------------------------------------------------------------------
module contador_de_passos (
    input  logic       clock,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    output logic [1:0] count
);
    logic [1:0] count_q;

    always_ff @(posedge clock) begin
        if (!resetn || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 2'd1;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/sequenciador_de_programa.sv
// ---------------------------------------------------------------------------
// sequenciador_de_programa
// Program sequencer: fetches 9-bit instructions (plus an immediate word for
// LDI) from a ROM with one cycle of read latency and presents each one to
// the control logic for four execution steps.
//   clock  : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : sequenciador_de_programa_if.master (run/stop/mem_data in;
//            mem_addr/mem_rd/iin/imm/counter/exec_valid/done/busy/halted out)
// Optional: SEQ_BREAKPOINT_EN adds a single address breakpoint
//   (bp_addr/bp_enable in, bp_hit out).
// ---------------------------------------------------------------------------
module sequenciador_de_programa
    import sequenciador_de_programa_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 5
) (
    input  logic clock,
    input  logic resetn,
    sequenciador_de_programa_if.master bus
);
    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    logic [2:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    instr_t              ir_q, ir_d;
    instr_t              imm_q, imm_d;
    logic                stop_q, stop_d;
    logic                busy_int;
    logic [1:0]          step;
`ifdef SEQ_BREAKPOINT_EN
    logic                skip_q, skip_d;
    logic                bp_hit_q, bp_hit_d;
`endif

    assign busy_int = (state_q != ST_IDLE) && (state_q != ST_HALT);

    contador_de_passos u_contador (
        .clock  (clock),
        .resetn (resetn),
        .clear  (state_q != ST_EXEC),
        .enable (state_q == ST_EXEC),
        .count  (step)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        imm_d   = imm_q;
        stop_d  = stop_q;
`ifdef SEQ_BREAKPOINT_EN
        skip_d   = skip_q;
        bp_hit_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.run && !bus.stop) state_d = ST_FETCH;
            end
            ST_FETCH:     state_d = ST_WAIT_IR;
            ST_WAIT_IR: begin
                ir_d = bus.mem_data;
                pc_d = pc_q + PC_ONE;
                case (opcode_of(bus.mem_data))
                    OP_HLT:  state_d = ST_HALT;
                    OP_LDI:  state_d = ST_FETCH_IMM;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_FETCH_IMM: state_d = ST_WAIT_IMM;
            ST_WAIT_IMM: begin
                imm_d   = bus.mem_data;
                pc_d    = pc_q + PC_ONE;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (step == 2'd3) state_d = (stop_q || bus.stop) ? ST_IDLE : ST_FETCH;
            end
            ST_HALT: begin
                if (bus.run) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef SEQ_BREAKPOINT_EN
        // Redirect a pending FETCH of the breakpoint address to IDLE; the skip
        // flag lets the following run fetch it once without re-breaking.
        if (state_q == ST_FETCH) skip_d = 1'b0;
        if (state_d == ST_FETCH && bus.bp_enable && pc_d == bus.bp_addr && !skip_q) begin
            state_d  = ST_IDLE;
            bp_hit_d = 1'b1;
            skip_d   = 1'b1;
        end
`endif

        // Sticky stop: set by stop while busy, dropped on reaching IDLE, and
        // also on reaching HALT so a stale request cannot outlive the halt.
        if (busy_int && bus.stop) stop_d = 1'b1;
        if (state_d == ST_IDLE || state_d == ST_HALT) stop_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            imm_q   <= '0;
            stop_q  <= 1'b0;
`ifdef SEQ_BREAKPOINT_EN
            skip_q   <= 1'b0;
            bp_hit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
            stop_q  <= stop_d;
`ifdef SEQ_BREAKPOINT_EN
            skip_q   <= skip_d;
            bp_hit_q <= bp_hit_d;
`endif
        end
    end

    // Status strobes are gated with resetn so they read 0 during reset even
    // before the first reset edge has cleared the state register.
    assign bus.mem_addr   = pc_q;
    assign bus.mem_rd     = resetn && (state_q == ST_FETCH || state_q == ST_FETCH_IMM);
    assign bus.iin        = ir_q;
    assign bus.imm        = imm_q;
    assign bus.exec_valid = resetn && (state_q == ST_EXEC);
    assign bus.counter    = bus.exec_valid ? step : 2'b00;
    assign bus.done       = bus.exec_valid && (step == 2'd3);
    assign bus.busy       = resetn && busy_int;
    assign bus.halted     = resetn && (state_q == ST_HALT);
`ifdef SEQ_BREAKPOINT_EN
    assign bus.bp_hit     = resetn && bp_hit_q;
`endif
endmodule
